mux2_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 16-bit 2:1 selection path. It grants one of two requesters, A or B, at a time, drives the select and the registered selected data, and holds each grant for a minimum dwell so the downstream consumer (display or register) sees stable data. It sits between two data producers and the shared display/output path.

---
 rtl/mux2_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mux2_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_arbiter
//   Round-robin arbiter for a shared WIDTH-bit 2:1 selection path. One of two
//   requesters (A or B) owns the path at a time. Each grant is held for at
//   least DWELL cycles so the downstream consumer sees stable data. The
//   selected data is registered and tracks the live source while a grant is
//   active. In IDLE the select and data hold their last values.
//
//   Optional feature (compile-time macro MUX2_ARBITER_AUTO_SCAN_EN):
//   when the block is idle with no requests, it auto-scans. The select
//   alternates A/B every DWELL cycles while the grants stay low. Any request
//   ends the scan and is arbitrated normally.
//
// Parameters
//   WIDTH : data width of both sources and the output
//   DWELL : minimum grant length in cycles (>= 1)
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high reset
//   req_a   : requester A wants the path
//   req_b   : requester B wants the path
//   a, b    : source data
//   s       : registered select (0 = A, 1 = B)
//   y       : registered selected data
//   grant_a : A owns the path (decoded from the state register)
//   grant_b : B owns the path (decoded from the state register)
//   busy    : either grant active
// ---------------------------------------------------------------------------
module mux2_arbiter #(
  parameter int WIDTH = 16,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             grant_a,
  output logic             grant_b,
  output logic             busy
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

`ifdef MUX2_ARBITER_AUTO_SCAN_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GNT_A  = 3'd1,
    ST_GNT_B  = 3'd2,
    ST_SCAN_A = 3'd3,
    ST_SCAN_B = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_t;
`endif

  state_t            state_r;
  state_t            state_nxt_s;
  state_t            arb_s;
  logic [CW-1:0]     cnt_r;
  logic              last_b_r;     // 1 = B was served last
  logic              s_r;
  logic [WIDTH-1:0]  y_r;
  logic              dwell_done_s;
  logic              sel_a_s;
  logic              sel_b_s;

  // Next-state logic: idle arbitration, dwell hold and grant hand-over
  always_comb begin
    state_nxt_s  = state_r;
    arb_s        = ST_IDLE;
    dwell_done_s = (cnt_r == DWELL_LAST);

    // Round-robin pick used whenever the path is free to be re-arbitrated
    if (req_a && req_b) begin
      arb_s = last_b_r ? ST_GNT_A : ST_GNT_B;
    end else if (req_a) begin
      arb_s = ST_GNT_A;
    end else if (req_b) begin
      arb_s = ST_GNT_B;
    end else begin
`ifdef MUX2_ARBITER_AUTO_SCAN_EN
      arb_s = last_b_r ? ST_SCAN_A : ST_SCAN_B;
`else
      arb_s = ST_IDLE;
`endif
    end

    case (state_r)
      ST_IDLE: begin
        state_nxt_s = arb_s;
      end
      ST_GNT_A: begin
        if (!dwell_done_s) begin
          state_nxt_s = ST_GNT_A;
        end else if (req_b) begin
          state_nxt_s = ST_GNT_B;
        end else if (!req_a) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GNT_A;
        end
      end
      ST_GNT_B: begin
        if (!dwell_done_s) begin
          state_nxt_s = ST_GNT_B;
        end else if (req_a) begin
          state_nxt_s = ST_GNT_A;
        end else if (!req_b) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GNT_B;
        end
      end
`ifdef MUX2_ARBITER_AUTO_SCAN_EN
      ST_SCAN_A: begin
        if (req_a || req_b) begin
          state_nxt_s = arb_s;
        end else if (dwell_done_s) begin
          state_nxt_s = ST_SCAN_B;
        end else begin
          state_nxt_s = ST_SCAN_A;
        end
      end
      ST_SCAN_B: begin
        if (req_a || req_b) begin
          state_nxt_s = arb_s;
        end else if (dwell_done_s) begin
          state_nxt_s = ST_SCAN_A;
        end else begin
          state_nxt_s = ST_SCAN_B;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Decode which source the output register loads on this edge
  always_comb begin
    sel_a_s = 1'b0;
    sel_b_s = 1'b0;
    case (state_nxt_s)
      ST_GNT_A:  sel_a_s = 1'b1;
      ST_GNT_B:  sel_b_s = 1'b1;
`ifdef MUX2_ARBITER_AUTO_SCAN_EN
      ST_SCAN_A: sel_a_s = 1'b1;
      ST_SCAN_B: sel_b_s = 1'b1;
`endif
      default: begin
        sel_a_s = 1'b0;
        sel_b_s = 1'b0;
      end
    endcase
  end

  // State, dwell counter and round-robin history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      last_b_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      // Any state change restarts the dwell; otherwise count and saturate
      if (state_nxt_s != state_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r != DWELL_LAST) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (sel_a_s) begin
        last_b_r <= 1'b0;
      end else if (sel_b_s) begin
        last_b_r <= 1'b1;
      end else begin
        last_b_r <= last_b_r;
      end
    end
  end

  // Registered select and data; both hold while no source is selected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_r <= 1'b0;
      y_r <= {WIDTH{1'b0}};
    end else if (sel_a_s) begin
      s_r <= 1'b0;
      y_r <= a;
    end else if (sel_b_s) begin
      s_r <= 1'b1;
      y_r <= b;
    end else begin
      s_r <= s_r;
      y_r <= y_r;
    end
  end

  assign s       = s_r;
  assign y       = y_r;
  assign grant_a = (state_r == ST_GNT_A);
  assign grant_b = (state_r == ST_GNT_B);
  assign busy    = grant_a | grant_b;

endmodule

// File: tb/tb_mux2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_arbiter
//   Directed self-checking bench for mux2_arbiter. A DWELL=4 instance is the
//   main target; a DWELL=1 instance shares the inputs to show per-cycle
//   alternation. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mux2_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a;
  logic        req_b;
  logic [15:0] a;
  logic [15:0] b;
  logic        s;
  logic [15:0] y;
  logic        grant_a;
  logic        grant_b;
  logic        busy;
  logic        s1;
  logic [15:0] y1;
  logic        grant_a1;
  logic        grant_b1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  mux2_arbiter #(.WIDTH(16), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .s(s), .y(y), .grant_a(grant_a), .grant_b(grant_b), .busy(busy)
  );

  mux2_arbiter #(.WIDTH(16), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .s(s1), .y(y1), .grant_a(grant_a1), .grant_b(grant_b1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    tick();
    tick();
    // Reset state
    chk("rst_s",   {31'd0, s},       32'd0);
    chk("rst_y",   {16'd0, y},       32'd0);
    chk("rst_ga",  {31'd0, grant_a}, 32'd0);
    chk("rst_gb",  {31'd0, grant_b}, 32'd0);
    chk("rst_busy",{31'd0, busy},    32'd0);
    reset = 1'b0;

    // Single requester, one-cycle request, four-cycle dwell
    req_a = 1'b1;
    a     = 16'hcde3;
    tick();
    req_a = 1'b0;
    chk("single_ga",   {31'd0, grant_a}, 32'd1);
    chk("single_y",    {16'd0, y},       {16'd0, 16'hcde3});
    chk("single_s",    {31'd0, s},       32'd0);
    chk("single_busy", {31'd0, busy},    32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("single_hold%0d", i), {31'd0, grant_a}, 32'd1);
    end
    tick();
    chk("single_idle_ga",   {31'd0, grant_a}, 32'd0);
    chk("single_idle_busy", {31'd0, busy},    32'd0);
    chk("single_idle_y",    {16'd0, y},       {16'd0, 16'hcde3});
`ifndef MUX2_ARBITER_AUTO_SCAN_EN
    tick();
    tick();
    chk("idle_hold_y", {16'd0, y}, {16'd0, 16'hcde3});
    chk("idle_hold_s", {31'd0, s}, 32'd0);
`endif

    // Tie after reset: A first, then B, then A, no idle gap
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    a     = 16'ha5a5;
    b     = 16'h5a5a;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i <= 4) begin
        chk($sformatf("tie_ga%0d", i), {31'd0, grant_a}, 32'd1);
        chk($sformatf("tie_ya%0d", i), {16'd0, y},       {16'd0, 16'ha5a5});
      end else begin
        chk($sformatf("tie_gb%0d", i), {31'd0, grant_b}, 32'd1);
        chk($sformatf("tie_yb%0d", i), {16'd0, y},       {16'd0, 16'h5a5a});
        chk($sformatf("tie_sb%0d", i), {31'd0, s},       32'd1);
      end
      chk($sformatf("tie_busy%0d", i), {31'd0, busy}, 32'd1);
      // DWELL=1 instance alternates every cycle starting with A
      chk($sformatf("d1_ga%0d", i), {31'd0, grant_a1}, {31'd0, (i % 2 == 1)});
      chk($sformatf("d1_gb%0d", i), {31'd0, grant_b1}, {31'd0, (i % 2 == 0)});
    end
    tick();
    chk("tie_back_a_ga", {31'd0, grant_a}, 32'd1);
    chk("tie_back_a_gb", {31'd0, grant_b}, 32'd0);
    chk("tie_back_a_y",  {16'd0, y},       {16'd0, 16'ha5a5});

    // Live tracking of the owner's data; other source ignored
    a = 16'h0000;
    tick();
    chk("live_y0", {16'd0, y}, {16'd0, 16'h0000});
    a = 16'hffff;
    b = 16'h1234;
    tick();
    chk("live_yf", {16'd0, y}, {16'd0, 16'hffff});
    req_a = 1'b0;
    req_b = 1'b0;
    b = 16'h4321;
    tick();
    chk("live_b_ignored", {16'd0, y}, {16'd0, 16'hffff});
    chk("live_s",         {31'd0, s}, 32'd0);
    tick();
    chk("live_end_ga", {31'd0, grant_a}, 32'd0);
    chk("live_end_y",  {16'd0, y},       {16'd0, 16'hffff});

    // Early drop: B requests for one cycle, grant still lasts four cycles
    req_b = 1'b1;
    b     = 16'h1234;
    tick();
    req_b = 1'b0;
    chk("drop_gb1", {31'd0, grant_b}, 32'd1);
    chk("drop_s",   {31'd0, s},       32'd1);
    chk("drop_y",   {16'd0, y},       {16'd0, 16'h1234});
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("drop_gb%0d", i), {31'd0, grant_b}, 32'd1);
    end
    tick();
    chk("drop_idle_gb", {31'd0, grant_b}, 32'd0);
    chk("drop_idle_busy", {31'd0, busy}, 32'd0);

    // Reset asserted mid-grant acts without a clock edge
    req_a = 1'b1;
    tick();
    chk("pre_rst_ga", {31'd0, grant_a}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_s",    {31'd0, s},       32'd0);
    chk("mid_rst_y",    {16'd0, y},       32'd0);
    chk("mid_rst_ga",   {31'd0, grant_a}, 32'd0);
    chk("mid_rst_gb",   {31'd0, grant_b}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy},    32'd0);
    tick();
    reset = 1'b0;
    req_b = 1'b1;
    tick();
    // History restored to B, so A wins the tie again
    chk("post_rst_tie_ga", {31'd0, grant_a}, 32'd1);
    chk("post_rst_tie_gb", {31'd0, grant_b}, 32'd0);
    req_a = 1'b0;
    req_b = 1'b0;

`ifdef MUX2_ARBITER_AUTO_SCAN_EN
    // Auto-scan: no requests after reset, select alternates every 4 cycles
    tick();
    reset = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("scan_s%0d", i), {31'd0, s},
          {31'd0, (i >= 5 && i <= 8)});
      chk($sformatf("scan_y%0d", i), {16'd0, y},
          {16'd0, ((i >= 5 && i <= 8) ? 16'h2222 : 16'h1111)});
      chk($sformatf("scan_busy%0d", i), {31'd0, busy}, 32'd0);
    end
    req_b = 1'b1;
    tick();
    chk("scan_abort_gb", {31'd0, grant_b}, 32'd1);
    chk("scan_abort_y",  {16'd0, y},       {16'd0, 16'h2222});
    req_b = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
